// File: rtl/mem_port_arbiter.sv
// Shares one dual-port memory (1-cycle read latency) between NUM_REQ requesters.
// Read and write ports are arbitrated independently by round-robin; a same-address read yields to the write.
module mem_port_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int MEM_WIDTH_BYTES = 8,
    parameter int MEM_DEPTH       = 1024,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int DW = MEM_WIDTH_BYTES * 8,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0][AW-1:0]        req_addr_in,
    input  logic [NUM_REQ-1:0]                req_read_in,
    input  logic [NUM_REQ-1:0]                req_write_in,
    input  logic [NUM_REQ-1:0][DW-1:0]        req_wdata_in,
    input  logic [NUM_REQ-1:0][MEM_WIDTH_BYTES-1:0] req_wmask_in,
    output logic [NUM_REQ-1:0]                req_ready_out,
    output logic [NUM_REQ-1:0]                resp_valid_out,
    output logic [DW-1:0]                     resp_data_out,
    output logic [AW-1:0]                     mem_write_addr_out,
    output logic                              mem_write_out,
    output logic [DW-1:0]                     mem_write_data_out,
    output logic [MEM_WIDTH_BYTES-1:0]        mem_write_mask_out,
    output logic [AW-1:0]                     mem_read_addr_out,
    output logic                              mem_read_out,
    input  logic [DW-1:0]                     mem_read_data_in,
    input  logic                              debugen_in
);

    // Handshake: a requester holds its request fields stable until req_ready_out[i]=1;
    // the transfer happens in that same cycle and read data follows one cycle later.

    // Returns {found, index}: first set bit of reqs scanning upward from ptr with wrap.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] reqs,
                                            input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int idx;
        res = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!res[PW] && reqs[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        return (w == PW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
    endfunction

    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [PW:0]        wr_pick, rd_pick;
    logic [PW-1:0]      wr_win, rd_win;
    logic               wr_valid, rd_valid, hazard;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt, rd_elig;
    logic [NUM_REQ-1:0] resp_valid_q;

    assign wr_pick  = rr_pick(req_write_in, wr_ptr);
    assign wr_win   = wr_pick[PW-1:0];
    assign wr_valid = !reset && wr_pick[PW];

    always_comb begin
        wr_gnt = '0;
        if (wr_valid) wr_gnt[wr_win] = 1'b1;
    end

    // A requester that just won the write port cannot also take the read port.
    assign rd_elig  = req_read_in & ~wr_gnt;
    assign rd_pick  = rr_pick(rd_elig, rd_ptr);
    assign rd_win   = rd_pick[PW-1:0];
    assign hazard   = wr_valid && (req_addr_in[rd_win] == req_addr_in[wr_win]);
    assign rd_valid = !reset && rd_pick[PW] && !hazard;

    always_comb begin
        rd_gnt = '0;
        if (rd_valid) rd_gnt[rd_win] = 1'b1;
    end

    assign req_ready_out      = wr_gnt | rd_gnt;
    assign mem_write_out      = wr_valid;
    assign mem_write_addr_out = req_addr_in[wr_win];
    assign mem_write_data_out = req_wdata_in[wr_win];
    assign mem_write_mask_out = req_wmask_in[wr_win];
    assign mem_read_out       = rd_valid;
    assign mem_read_addr_out  = req_addr_in[rd_win];

    // Gating with reset drops the response of a read granted just before reset.
    assign resp_valid_out = resp_valid_q & {NUM_REQ{~reset}};
    assign resp_data_out  = mem_read_data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            resp_valid_q <= '0;
        end else begin
            if (wr_valid) wr_ptr <= next_ptr(wr_win);
            if (rd_valid) rd_ptr <= next_ptr(rd_win);
            resp_valid_q <= rd_gnt;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (debugen_in && !reset) begin
            $write("[mem_port_arbiter] t=%0t wr_gnt=%b rd_gnt=%b hazard=%b resp=%b\n",
                   $time, wr_gnt, rd_gnt, hazard, resp_valid_out);
            for (int i = 0; i < NUM_REQ; i++)
                if (req_read_in[i] && req_write_in[i])
                    $write("[mem_port_arbiter] req %0d: illegal read+write, read left pending\n", i);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a behavioural 1-cycle-latency memory behind it.
// Expected grants, addresses and read data are hand-computed in the vector table.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int MW = 8;

    logic                   clk;
    logic                   reset;
    logic [NR-1:0][AW-1:0]  req_addr_in;
    logic [NR-1:0]          req_read_in;
    logic [NR-1:0]          req_write_in;
    logic [NR-1:0][DW-1:0]  req_wdata_in;
    logic [NR-1:0][MW-1:0]  req_wmask_in;
    logic [NR-1:0]          req_ready_out;
    logic [NR-1:0]          resp_valid_out;
    logic [DW-1:0]          resp_data_out;
    logic [AW-1:0]          mem_write_addr_out;
    logic                   mem_write_out;
    logic [DW-1:0]          mem_write_data_out;
    logic [MW-1:0]          mem_write_mask_out;
    logic [AW-1:0]          mem_read_addr_out;
    logic                   mem_read_out;
    logic [DW-1:0]          mem_read_data_in;
    logic                   debugen_in;

    mem_port_arbiter #(.NUM_REQ(NR), .MEM_WIDTH_BYTES(MW), .MEM_DEPTH(1024)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_addr_in        (req_addr_in),
        .req_read_in        (req_read_in),
        .req_write_in       (req_write_in),
        .req_wdata_in       (req_wdata_in),
        .req_wmask_in       (req_wmask_in),
        .req_ready_out      (req_ready_out),
        .resp_valid_out     (resp_valid_out),
        .resp_data_out      (resp_data_out),
        .mem_write_addr_out (mem_write_addr_out),
        .mem_write_out      (mem_write_out),
        .mem_write_data_out (mem_write_data_out),
        .mem_write_mask_out (mem_write_mask_out),
        .mem_read_addr_out  (mem_read_addr_out),
        .mem_read_out       (mem_read_out),
        .mem_read_data_in   (mem_read_data_in),
        .debugen_in         (debugen_in)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory behind the arbiter ----------------
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (reset) begin
            mem[2] <= 64'h1122;
            mem[3] <= 64'hAA;
            mem[4] <= 64'hBB;
        end else if (mem_write_out) begin
            for (int b = 0; b < MW; b++)
                if (mem_write_mask_out[b])
                    mem[mem_write_addr_out][b*8 +: 8] <= mem_write_data_out[b*8 +: 8];
        end
        if (mem_read_out) mem_read_data_in <= mem[mem_read_addr_out];
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic          rst;
        logic [1:0]    rd, wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
        logic [1:0]    e_rdy;
        logic          e_mrd, e_mwr;
        logic [AW-1:0] e_raddr, e_waddr;
        logic [1:0]    e_rvalid;
        logic [DW-1:0] e_rdata;   // data the read granted in this row must return
    } vec_t;

    function automatic vec_t mk(logic rst, logic [1:0] rd, logic [1:0] wr,
                                logic [AW-1:0] a0, logic [AW-1:0] a1,
                                logic [DW-1:0] wd, logic [MW-1:0] wm,
                                logic [1:0] e_rdy, logic e_mrd, logic e_mwr,
                                logic [AW-1:0] e_raddr, logic [AW-1:0] e_waddr,
                                logic [1:0] e_rvalid, logic [DW-1:0] e_rdata);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.wd = wd; v.wm = wm;
        v.e_rdy = e_rdy; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
        v.e_raddr = e_raddr; v.e_waddr = e_waddr; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        reset           = v.rst;
        req_read_in     = v.rd;
        req_write_in    = v.wr;
        req_addr_in[0]  = v.a0;
        req_addr_in[1]  = v.a1;
        req_wdata_in[0] = v.wd;
        req_wdata_in[1] = v.wd;
        req_wmask_in[0] = v.wm;
        req_wmask_in[1] = v.wm;
        @(negedge clk);
        chk({tag, " ready"},      DW'(req_ready_out),  DW'(v.e_rdy));
        chk({tag, " mem_read"},   DW'(mem_read_out),   DW'(v.e_mrd));
        chk({tag, " mem_write"},  DW'(mem_write_out),  DW'(v.e_mwr));
        chk({tag, " resp_valid"}, DW'(resp_valid_out), DW'(v.e_rvalid));
        if (v.e_mrd) chk({tag, " read_addr"}, DW'(mem_read_addr_out), DW'(v.e_raddr));
        if (v.e_mwr) begin
            chk({tag, " write_addr"}, DW'(mem_write_addr_out), DW'(v.e_waddr));
            chk({tag, " write_data"}, mem_write_data_out, v.wd);
            chk({tag, " write_mask"}, DW'(mem_write_mask_out), DW'(v.wm));
        end
        if (resp_valid_out != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s resp_unexpected: got valid=%b, expected no response", tag, resp_valid_out);
            end else begin
                chk({tag, " resp_data"}, resp_data_out, exp_q.pop_front());
            end
        end
        if (v.e_mrd) exp_q.push_back(v.e_rdata);
    endtask

    vec_t tbl[$];

    initial begin
        reset        = 1'b1;
        req_read_in  = '0;
        req_write_in = '0;
        req_addr_in  = '0;
        req_wdata_in = '0;
        req_wmask_in = '0;
        debugen_in   = 1'b0;

        // reset held with everything requesting: nothing may be granted
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 2'b11, 2'b11, 1, 2, 64'h1, 8'hFF, 2'b00, 0, 0, 0, 0, 2'b00, 0));
        // idle after reset
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0));
        // single read of addr 3
        tbl.push_back(mk(0, 2'b01, 2'b00, 3, 0, 0, 0, 2'b01, 1, 0, 3, 0, 2'b00, 64'hAA));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
        // both read continuously: rd_ptr is 1 now, so 1,0,1,0
        tbl.push_back(mk(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b10, 1, 0, 4, 0, 2'b00, 64'hBB));
        tbl.push_back(mk(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b01, 1, 0, 3, 0, 2'b10, 64'hAA));
        tbl.push_back(mk(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b10, 1, 0, 4, 0, 2'b01, 64'hBB));
        tbl.push_back(mk(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b01, 1, 0, 3, 0, 2'b10, 64'hAA));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
        // hazard: req1 writes 0x55 to 7 while req0 reads 7
        tbl.push_back(mk(0, 2'b01, 2'b10, 7, 7, 64'h55, 8'hFF, 2'b10, 0, 1, 0, 7, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 7, 7, 0, 0, 2'b01, 1, 0, 7, 0, 2'b00, 64'h55));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
        // byte-masked write then read back
        tbl.push_back(mk(0, 2'b00, 2'b10, 0, 2, 64'hFF, 8'h01, 2'b10, 0, 1, 0, 2, 2'b00, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 2, 0, 0, 2'b10, 1, 0, 2, 0, 2'b00, 64'h11FF));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 0));
        // illegal read+write on req0: write first, read stays pending
        tbl.push_back(mk(0, 2'b01, 2'b01, 5, 0, 64'h77, 8'hFF, 2'b01, 0, 1, 0, 5, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, 5, 0, 0, 0, 2'b01, 1, 0, 5, 0, 2'b00, 64'h77));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
        // write round-robin: wr_ptr is 1
        tbl.push_back(mk(0, 2'b00, 2'b11, 8, 9, 64'h99, 8'hFF, 2'b10, 0, 1, 0, 9, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 2'b01, 8, 9, 64'h88, 8'hFF, 2'b01, 0, 1, 0, 8, 2'b00, 0));
        // read and write on different addresses in the same cycle
        tbl.push_back(mk(0, 2'b01, 2'b10, 3, 9, 64'h66, 8'hFF, 2'b11, 1, 1, 3, 9, 2'b00, 64'hAA));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));
        // read back 9 and 8
        tbl.push_back(mk(0, 2'b11, 2'b00, 8, 9, 0, 0, 2'b10, 1, 0, 9, 0, 2'b00, 64'h66));
        tbl.push_back(mk(0, 2'b01, 2'b00, 8, 9, 0, 0, 2'b01, 1, 0, 8, 0, 2'b10, 64'h88));
        tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // reset one cycle after a read grant: no response, pointers back to 0
        apply(mk(0, 2'b01, 2'b00, 3, 0, 0, 0, 2'b01, 1, 0, 3, 0, 2'b00, 64'hAA), "rst_grant");
        exp_q.delete();
        apply(mk(1, 2'b11, 2'b10, 3, 9, 64'h1, 8'hFF, 2'b00, 0, 0, 0, 0, 2'b00, 0), "rst_hold0");
        apply(mk(1, 2'b11, 2'b10, 3, 9, 64'h1, 8'hFF, 2'b00, 0, 0, 0, 0, 2'b00, 0), "rst_hold1");
        apply(mk(0, 2'b11, 2'b00, 3, 4, 0, 0, 2'b01, 1, 0, 3, 0, 2'b00, 64'hAA), "rst_first");
        apply(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 0), "rst_resp");

        chk("scoreboard_drained", DW'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
